// File: rtl/ped_walk_controller.sv
// Per-approach pedestrian WALK / DONT_WALK sequencer driven by vehicle lights.
// Optional conflict monitor compiled in with `define PED_CONFLICT_MON_EN.
module ped_walk_controller #(
  parameter int unsigned WALK_CYCLES  = 8,
  parameter int unsigned FLASH_CYCLES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] north_light,
  input  logic [2:0] west_light,
  input  logic [2:0] south_light,
  input  logic [2:0] east_light,
  input  logic [3:0] ped_btn,
  output logic [3:0] walk,
  output logic [3:0] dont_walk,
  output logic [3:0] ped_pending,
  output logic       fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WALK,
    S_FLASH
  } state_e;

  localparam logic [7:0] WALK_LOAD  = 8'(WALK_CYCLES - 1);
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_CYCLES - 1);

  state_e     state_q [4];
  state_e     state_d [4];
  logic [7:0] cnt_q   [4];
  logic [7:0] cnt_d   [4];

  logic [3:0] g;
  logic [3:0] onset;
  logic [3:0] prev_g_q;
  logic [3:0] walk_q, walk_d;
  logic [3:0] dw_q, dw_d;
  logic [3:0] pend_q, pend_d;
  logic       hold;

  assign g = {east_light[0], south_light[0],
              west_light[0], north_light[0]};
  assign onset = g & ~prev_g_q;

`ifdef PED_CONFLICT_MON_EN
  logic fault_q, fault_d, viol;

  function automatic logic legal(input logic [2:0] l);
    return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
  endfunction

  always_comb begin
    viol = !legal(north_light) || !legal(west_light) ||
           !legal(south_light) || !legal(east_light) ||
           ($countones(g) > 1);
  end

  assign fault_d = fault_q | viol;
  // Force outputs on the same edge the flag sets.
  assign hold    = fault_d;
  assign fault   = fault_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
`else
  logic unused_light_bits;
  assign unused_light_bits = ^{north_light[2:1], west_light[2:1],
                               south_light[2:1], east_light[2:1]};
  assign hold  = 1'b0;
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
      prev_g_q <= '0;
      walk_q   <= '0;
      dw_q     <= 4'hF;
      pend_q   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      prev_g_q <= g;
      walk_q   <= walk_d;
      dw_q     <= dw_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    pend_d = pend_q | ped_btn;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_IDLE: begin
          if (pend_d[i]) state_d[i] = S_WAIT;
        end
        S_WAIT: begin
          if (onset[i]) begin
            state_d[i] = S_WALK;
            cnt_d[i]   = WALK_LOAD;
            pend_d[i]  = 1'b0;
          end
        end
        S_WALK: begin
          if (!g[i]) begin
            state_d[i] = S_IDLE;
          end else if (cnt_q[i] == 8'd0) begin
            state_d[i] = S_FLASH;
            cnt_d[i]   = FLASH_LOAD;
          end else begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end
        end
        S_FLASH: begin
          if (!g[i]) begin
            state_d[i] = S_IDLE;
          end else if (cnt_q[i] == 8'd0) begin
            state_d[i] = pend_d[i] ? S_WAIT : S_IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
      if (hold) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
        pend_d[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    walk_d = '0;
    dw_d   = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (state_d[i] == S_WALK) begin
        walk_d[i] = 1'b1;
        dw_d[i]   = 1'b0;
      end else if (state_d[i] == S_FLASH) begin
        dw_d[i] = (state_q[i] == S_FLASH) ? ~dw_q[i] : 1'b1;
      end
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dw_q;
  assign ped_pending = pend_q;

endmodule

// File: tb/tb_ped_walk_controller.sv
// Bench for ped_walk_controller: directed scenarios plus random
// traffic checked against a timestamp-based pedestrian model.
module tb_ped_walk_controller;
  localparam int W = 8;
  localparam int F = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] north_light, west_light, south_light, east_light;
  logic [3:0] ped_btn;
  logic [3:0] walk, dont_walk, ped_pending;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;

  ped_walk_controller #(
    .WALK_CYCLES (W),
    .FLASH_CYCLES(F)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .north_light(north_light),
    .west_light (west_light),
    .south_light(south_light),
    .east_light (east_light),
    .ped_btn    (ped_btn),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .ped_pending(ped_pending),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  // Model: a grant is a timestamp; outputs follow from elapsed cycles.
  int         cyc = 0;
  bit         m_act   [4];
  int         m_start [4];
  bit         m_req   [4];
  bit         m_arm   [4];
  bit         m_prevg [4];
  bit         m_fault;
  logic [3:0] exp_walk, exp_dw, exp_pend;
  logic       exp_fault;

  function automatic void model_outputs();
    int e;
    for (int i = 0; i < 4; i++) begin
      exp_walk[i] = 1'b0;
      exp_dw[i]   = 1'b1;
      exp_pend[i] = m_req[i];
      if (m_act[i]) begin
        e = cyc - m_start[i];
        exp_walk[i] = (e < W);
        exp_dw[i]   = (e < W) ? 1'b0 : (((e - W) % 2) == 0);
      end
    end
    exp_fault = m_fault;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_act[i]   = 0;
      m_start[i] = 0;
      m_req[i]   = 0;
      m_arm[i]   = 0;
      m_prevg[i] = 0;
    end
    m_fault = 0;
    model_outputs();
  endfunction

  function automatic bit is_legal(input logic [2:0] l);
    return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
  endfunction

  function automatic void model_step();
    bit g [4];
    bit b;
    g[0] = north_light[0];
    g[1] = west_light[0];
    g[2] = south_light[0];
    g[3] = east_light[0];
`ifdef PED_CONFLICT_MON_EN
    begin
      int ng;
      ng = int'(g[0]) + int'(g[1]) + int'(g[2]) + int'(g[3]);
      if (ng > 1 || !is_legal(north_light) || !is_legal(west_light) ||
          !is_legal(south_light) || !is_legal(east_light))
        m_fault = 1;
    end
`endif
    cyc++;
    for (int i = 0; i < 4; i++) begin
      b = ped_btn[i];
      if (m_fault) begin
        m_act[i] = 0;
        m_arm[i] = 0;
        m_req[i] = 0;
      end else if (m_act[i]) begin
        if (!g[i]) begin
          m_act[i] = 0;
          m_arm[i] = 0;
          m_req[i] = m_req[i] | b;
        end else if (cyc - m_start[i] >= W + F) begin
          m_act[i] = 0;
          m_req[i] = m_req[i] | b;
          m_arm[i] = m_req[i];
        end else begin
          m_req[i] = m_req[i] | b;
        end
      end else if (m_arm[i] && g[i] && !m_prevg[i]) begin
        m_act[i]   = 1;
        m_start[i] = cyc;
        m_req[i]   = 0;
        m_arm[i]   = 0;
      end else begin
        m_req[i] = m_req[i] | b;
        m_arm[i] = m_req[i];
      end
      m_prevg[i] = g[i];
    end
    model_outputs();
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic all_red();
    north_light = 3'b100;
    west_light  = 3'b100;
    south_light = 3'b100;
    east_light  = 3'b100;
  endtask

  task automatic set_light(input int k, input logic [2:0] v);
    case (k)
      0: north_light = v;
      1: west_light  = v;
      2: south_light = v;
      default: east_light = v;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    ped_btn = '0;
    all_red();
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (walk !== 4'h0 || dont_walk !== 4'hF ||
        ped_pending !== 4'h0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got w=%h dw=%h p=%h f=%b expected 0 f 0 0",
               walk, dont_walk, ped_pending, fault);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    n_checks++;
    if (walk !== 4'h0 || dont_walk !== 4'hF ||
        ped_pending !== 4'h0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got w=%h dw=%h p=%h f=%b expected 0 f 0 0",
               walk, dont_walk, ped_pending, fault);
    end
  endtask

  task automatic test_walk_grant();
    logic exp;
    ped_btn = 4'b0010;
    tick();
    ped_btn = '0;
    n_checks++;
    if (ped_pending !== 4'b0010) begin
      n_fail++;
      $display("FAIL grant_pend_latch: got %h expected 2", ped_pending);
    end
    repeat (3) tick();
    n_checks++;
    if (walk[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL grant_no_early_walk: got %b expected 0", walk[1]);
    end
    west_light = 3'b001;
    for (int k = 0; k < W; k++) begin
      tick();
      n_checks++;
      if (walk[1] !== 1'b1 || dont_walk[1] !== 1'b0 ||
          ped_pending[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL grant_walk_%0d: got w=%b dw=%b p=%b expected 1 0 0",
                 k, walk[1], dont_walk[1], ped_pending[1]);
      end
    end
    for (int k = 0; k < F; k++) begin
      tick();
      exp = ((k % 2) == 0);
      n_checks++;
      if (walk[1] !== 1'b0 || dont_walk[1] !== exp) begin
        n_fail++;
        $display("FAIL grant_flash_%0d: got w=%b dw=%b expected 0 %b",
                 k, walk[1], dont_walk[1], exp);
      end
    end
    repeat (3) begin
      tick();
      n_checks++;
      if (walk[1] !== 1'b0 || dont_walk[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL grant_steady: got w=%b dw=%b expected 0 1",
                 walk[1], dont_walk[1]);
      end
    end
    west_light = 3'b100;
    tick();
  endtask

  task automatic test_mid_green();
    int seen = 0;
    north_light = 3'b001;
    repeat (5) tick();
    ped_btn = 4'b0001;
    tick();
    ped_btn = '0;
    n_checks++;
    if (ped_pending[0] !== 1'b1 || walk[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_green_latch: got p=%b w=%b expected 1 0",
               ped_pending[0], walk[0]);
    end
    repeat (10) begin
      tick();
      if (walk[0] === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_green_no_walk: got %0d walk cycles expected 0", seen);
    end
    north_light = 3'b010;
    repeat (3) tick();
    north_light = 3'b100;
    repeat (5) tick();
    n_checks++;
    if (ped_pending[0] !== 1'b1 || walk[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_green_wait: got p=%b w=%b expected 1 0",
               ped_pending[0], walk[0]);
    end
    north_light = 3'b001;
    tick();
    n_checks++;
    if (walk[0] !== 1'b1 || ped_pending[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_green_next_onset: got w=%b p=%b expected 1 0",
               walk[0], ped_pending[0]);
    end
    repeat (W + F) tick();
    n_checks++;
    if (walk[0] !== 1'b0 || dont_walk[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_green_done: got w=%b dw=%b expected 0 1",
               walk[0], dont_walk[0]);
    end
    north_light = 3'b100;
    tick();
  endtask

  task automatic test_abort();
    int steady = 0;
    ped_btn = 4'b0001;
    tick();
    ped_btn = '0;
    north_light = 3'b001;
    repeat (4) tick();
    n_checks++;
    if (walk[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre_walk: got %b expected 1", walk[0]);
    end
    north_light = 3'b010;
    tick();
    n_checks++;
    if (walk[0] !== 1'b0 || dont_walk[0] !== 1'b1 ||
        ped_pending[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_walk: got w=%b dw=%b p=%b expected 0 1 0",
               walk[0], dont_walk[0], ped_pending[0]);
    end
    repeat (3) begin
      tick();
      if (dont_walk[0] === 1'b1 && walk[0] === 1'b0) steady++;
    end
    n_checks++;
    if (steady != 3) begin
      n_fail++;
      $display("FAIL abort_steady: got %0d steady cycles expected 3", steady);
    end
    north_light = 3'b100;
    tick();
    ped_btn = 4'b0001;
    tick();
    ped_btn = '0;
    north_light = 3'b001;
    repeat (W + 2) tick();
    n_checks++;
    if (walk[0] !== 1'b0 || dont_walk[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_flash: got w=%b dw=%b expected 0 0",
               walk[0], dont_walk[0]);
    end
    ped_btn = 4'b0001;
    tick();
    ped_btn = '0;
    north_light = 3'b010;
    tick();
    n_checks++;
    if (walk[0] !== 1'b0 || dont_walk[0] !== 1'b1 ||
        ped_pending[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_flash_keep: got w=%b dw=%b p=%b expected 0 1 1",
               walk[0], dont_walk[0], ped_pending[0]);
    end
    north_light = 3'b100;
    repeat (3) tick();
    north_light = 3'b001;
    tick();
    n_checks++;
    if (walk[0] !== 1'b1 || ped_pending[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_regrant: got w=%b p=%b expected 1 0",
               walk[0], ped_pending[0]);
    end
    north_light = 3'b010;
    tick();
    north_light = 3'b100;
    tick();
  endtask

  task automatic test_back_to_back();
    ped_btn = 4'b0100;
    tick();
    ped_btn = '0;
    south_light = 3'b001;
    tick();
    repeat (3) tick();
    ped_btn = 4'b0100;
    tick();
    ped_btn = '0;
    n_checks++;
    if (walk[2] !== 1'b1 || ped_pending[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_press_in_walk: got w=%b p=%b expected 1 1",
               walk[2], ped_pending[2]);
    end
    repeat (W + F - 4) tick();
    n_checks++;
    if (walk[2] !== 1'b0 || dont_walk[2] !== 1'b1 ||
        ped_pending[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_after_flash: got w=%b dw=%b p=%b expected 0 1 1",
               walk[2], dont_walk[2], ped_pending[2]);
    end
    repeat (2) tick();
    n_checks++;
    if (walk[2] !== 1'b0 || ped_pending[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_no_regrant: got w=%b p=%b expected 0 1",
               walk[2], ped_pending[2]);
    end
    south_light = 3'b010;
    repeat (2) tick();
    south_light = 3'b100;
    repeat (3) tick();
    south_light = 3'b001;
    tick();
    n_checks++;
    if (walk[2] !== 1'b1 || ped_pending[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_served: got w=%b p=%b expected 1 0",
               walk[2], ped_pending[2]);
    end
    repeat (W + F) tick();
    south_light = 3'b100;
    tick();
  endtask

  task automatic test_async_reset();
    ped_btn = 4'b1000;
    tick();
    ped_btn = '0;
    east_light = 3'b001;
    repeat (3) tick();
    n_checks++;
    if (walk[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got %b expected 1", walk[3]);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (walk !== 4'h0 || dont_walk !== 4'hF || ped_pending !== 4'h0) begin
      n_fail++;
      $display("FAIL areset_mid: got w=%h dw=%h p=%h expected 0 f 0",
               walk, dont_walk, ped_pending);
    end
    model_reset();
    east_light = 3'b100;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

`ifdef PED_CONFLICT_MON_EN
  task automatic test_fault();
    north_light = 3'b001;
    east_light  = 3'b001;
    tick();
    n_checks++;
    if (fault !== 1'b1 || walk !== 4'h0 || dont_walk !== 4'hF) begin
      n_fail++;
      $display("FAIL fault_set: got f=%b w=%h dw=%h expected 1 0 f",
               fault, walk, dont_walk);
    end
    all_red();
    ped_btn = 4'hF;
    tick();
    ped_btn = '0;
    west_light = 3'b001;
    repeat (3) tick();
    n_checks++;
    if (fault !== 1'b1 || walk !== 4'h0 || ped_pending !== 4'h0 ||
        dont_walk !== 4'hF) begin
      n_fail++;
      $display("FAIL fault_hold: got f=%b w=%h p=%h dw=%h expected 1 0 0 f",
               fault, walk, ped_pending, dont_walk);
    end
    all_red();
    do_reset();
    tick();
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clear: got %b expected 0", fault);
    end
    east_light = 3'b011;
    tick();
    n_checks++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_illegal_code: got %b expected 1", fault);
    end
    all_red();
    do_reset();
  endtask
`endif

  task automatic test_random();
    int k   = 0;
    int ph  = 0;
    int rem = 10;
    all_red();
    ped_btn = '0;
    do_reset();
    repeat (2500) begin
      all_red();
      if (ph == 0) set_light(k, 3'b001);
      else if (ph == 1) set_light(k, 3'b010);
      for (int i = 0; i < 4; i++)
        ped_btn[i] = ($urandom_range(0, 6) == 0);
      tick();
      n_checks++;
      if (walk !== exp_walk || dont_walk !== exp_dw ||
          ped_pending !== exp_pend || fault !== exp_fault) begin
        n_fail++;
        $display("FAIL random_c%0d: got w=%h dw=%h p=%h f=%b expected %h %h %h %b",
                 cyc, walk, dont_walk, ped_pending, fault,
                 exp_walk, exp_dw, exp_pend, exp_fault);
      end
      rem--;
      if (rem == 0) begin
        if (ph == 0) begin
          ph  = 1;
          rem = $urandom_range(1, 3);
        end else if (ph == 1) begin
          ph  = 2;
          rem = $urandom_range(1, 4);
        end else begin
          ph  = 0;
          k   = $urandom_range(0, 3);
          rem = $urandom_range(3, 30);
        end
      end
    end
    ped_btn = '0;
    all_red();
  endtask

  initial begin
    test_reset();
    test_walk_grant();
    test_mid_green();
    test_abort();
    test_back_to_back();
    test_async_reset();
`ifdef PED_CONFLICT_MON_EN
    test_fault();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ped_walk_controller.md
# ped_walk_controller

Pedestrian signal stage downstream of `traffic_controller`. It consumes the four 3-bit vehicle light outputs and latches per-approach pedestrian button requests. For each approach it drives WALK / DONT_WALK heads, granting a walk interval only at the onset of that approach's green. An optional conflict monitor forces all heads to steady DONT_WALK if the light inputs are illegal.

## Interface
- `WALK_CYCLES`, default 8: cycles WALK is held per grant; legal range 1..255.
- `FLASH_CYCLES`, default 6: cycles of flashing DONT_WALK after WALK; legal range 1..255.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset).
- `north_light`, `west_light`, `south_light`, `east_light`  input  3 each  vehicle lights. Encoding: bit2 red, bit1 yellow, bit0 green; legal codes are 3'b100, 3'b010 and 3'b001.
- `ped_btn`  input  4  button requests, index order [3:0] = {E,S,W,N}; synchronous; level or pulse.
- `walk`  output  4  WALK head per approach, same index order.
- `dont_walk`  output  4  DONT_WALK head per approach.
- `ped_pending`  output  4  request latched and not yet served.
- `fault`  output  1  latched conflict flag (only present when the monitor is compiled in; tied 0 otherwise).

## Operation
- Four identical per-approach FSMs: IDLE, WAIT, WALK, FLASH. Each has an 8-bit down-counter.
- All outputs are registered.
- Reset values: `walk`=4'b0000, `dont_walk`=4'b1111, `ped_pending`=4'b0000, `fault`=0. All FSMs start in IDLE, counters at 0, and previous-green registers at 0.
- `g_i` = bit0 of the approach's light input. Green onset = `g_i` & ~`prev_g_i`.
- IDLE:
  - `ped_btn[i]`=1 → WAIT and set `ped_pending[i]`.
  - `dont_walk[i]`=1.
- WAIT:
  - On green onset → WALK, load counter with WALK_CYCLES−1, clear `ped_pending[i]`.
  - A request arriving while the approach is already green (no onset) waits for the next green onset.
- WALK:
  - `walk[i]`=1, `dont_walk[i]`=0; counter decrements each cycle.
  - When counter=0 → FLASH, load counter with FLASH_CYCLES−1.
- FLASH:
  - `walk[i]`=0. `dont_walk[i]`=1 on the first FLASH cycle and toggles every cycle after.
  - When counter=0 → IDLE.
- Green drops during WALK or FLASH (`g_i`=0):
  - Immediate → IDLE, with `dont_walk[i]`=1 steady from the next edge.
  - The pending request is untouched.
- Button pressed in WALK or FLASH: sets `ped_pending[i]`. On return to IDLE the FSM goes straight to WAIT instead (no request lost).
- Button on the same edge as a green onset while in IDLE: only the IDLE→WAIT transition is taken; the grant happens at the next green onset.
- Approaches are independent. Two approaches in WALK simultaneously can only occur with conflicting greens, which the monitor (if enabled) catches.

## Timing
- Latency:
  - Light input change to FSM reaction: 1 edge.
  - Green visible on inputs to `walk[i]`=1: 1 cycle.
- WALK interval is exactly WALK_CYCLES cycles, followed by exactly FLASH_CYCLES flash cycles, then steady DONT_WALK.
- Button to `ped_pending` visible: 1 cycle.
- Asserting `reset` mid-operation returns all outputs to their reset values asynchronously.
- With default traffic timing (16-cycle green), a full grant (8+6 cycles) completes inside one green.

## Configuration
- `PED_CONFLICT_MON_EN` defined: the monitor is compiled in.
  - Each cycle it checks: any light input not one of the three legal codes, or more than one `g_i` set.
  - On a violation, `fault` sets at the next edge and stays set until `reset`.
  - While `fault`=1: `walk`=0, `dont_walk`=4'b1111 steady, `ped_pending` cleared, all FSMs held in IDLE, `ped_btn` ignored.
- `PED_CONFLICT_MON_EN` undefined: no monitor logic, `fault` constant 0, and illegal inputs are treated per bit0 only.

## Test plan
- Reset low for 2 cycles, then release → `walk`=0, `dont_walk`=4'b1111, `ped_pending`=0, `fault`=0.
- `ped_btn[1]` pulse while west is red, then west goes green → `walk[1]`=1 for 8 cycles starting 1 cycle after green; then `dont_walk[1]` runs 1,0,1,0,1,0; then steady 1; `ped_pending[1]` clears at WALK entry.
- `ped_btn[0]` pressed mid-way through north green → no walk this green; `walk[0]` is granted at the next north green onset (80 cycles later with default sequencing).
- `WALK_CYCLES`=20 with a 16-cycle green → WALK aborted when north goes yellow; `dont_walk[0]`=1 steady from the next cycle.
- `ped_btn[2]` pressed during a south WALK → after FLASH completes, the FSM enters WAIT and `ped_pending[2]`=1; it is served at the next south green.
- With `PED_CONFLICT_MON_EN` defined: drive north and east green together (or east=3'b011) → `fault`=1 next cycle; all `walk`=0 and `dont_walk`=4'b1111 until reset.
